motor_cmd_seq: RTL and testbench
================================

MOTOR_CMD_SEQ -- requirements
Module: motor_cmd_seq

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, debounce stability time in clk cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter RUN_CYCLES, default 25000000, cycles a motor request is held asserted.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, cycles with mot=0 between consecutive runs (min 1).
REQ-004 SHALL have parameter CNT_W, default 28, width of all internal counters.
REQ-005 Port clk  input  1  sole clock, all state on rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port btn  input  2  raw asynchronous push-buttons, bit i requests motor i, active-high.
REQ-008 Port mot  output  2  registered motor run requests to the downstream motor driver, at most one bit set.
REQ-009 Port busy  output  1  high in any state other than IDLE.
REQ-010 Port done  output  2  one-cycle pulse on bit i when a run of motor i ends.

Function
REQ-011 Each btn bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-012 Debounced level i SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any glitch restarts that counter.
REQ-013 A 0->1 transition of debounced level i SHALL set pend[i]; releasing the button SHALL NOT clear pend[i].
REQ-014 pend[i] SHALL hold at most one request; further presses while set are discarded.
REQ-015 FSM states SHALL be IDLE, RUN0, RUN1, GAP.
REQ-016 IDLE: if exactly one pend bit set, go to RUN of that motor; if both set, grant motor not served last (round-robin, motor 0 first after reset).
REQ-017 Entering RUNi SHALL clear pend[i], load run counter, and assert mot[i] on the first clock of that state.
REQ-018 mot[i] SHALL stay high exactly RUN_CYCLES cycles, then FSM goes to GAP with mot=00 and done[i] pulsed for one cycle.
REQ-019 A press of motor i during RUNi SHALL set pend[i] and be served after GAP, never extending the current run.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles with mot=00, then return to IDLE; IDLE-to-RUN takes one cycle.
REQ-021 mot SHALL never be 11; mot SHALL never change directly from 01 to 10 or 10 to 01.
REQ-022 Counters SHALL saturate/reload, never wrap; parameter values above 2^CNT_W-1 are illegal.
REQ-023 Simultaneous debounced edges on both buttons in IDLE SHALL resolve by REQ-016 in the same cycle.

Reset
REQ-024 rst_n low SHALL immediately force mot=00, done=00, busy=0, state IDLE, pend=00, round-robin pointer to motor 0, debounced levels 0, all counters 0.
REQ-025 Reset asserted mid-run SHALL drop mot within the same cycle (asynchronous), with no done pulse.
REQ-026 After rst_n rises, a button already held SHALL register as a press once debounced.

Configuration
REQ-027 Macro MOT_EMERGENCY_STOP_EN, when defined, SHALL add input port stop_n (1 bit, active-low, passed through a 2-flop synchronizer).
REQ-028 With MOT_EMERGENCY_STOP_EN, synchronized stop_n low SHALL force mot=00 next cycle, clear pend, suppress done, go to GAP, and hold in GAP while stop_n stays low.
REQ-029 Without MOT_EMERGENCY_STOP_EN, port stop_n and its logic SHALL not exist; behaviour is REQ-011..REQ-023 only.

Verification (DEB_CYCLES=4, RUN_CYCLES=10, GAP_CYCLES=3)
REQ-030 btn=01 held 8 cycles -> after sync+debounce mot=01 for exactly 10 cycles, done=01 one cycle, mot=00 for 3 cycles, busy back to 0.
REQ-031 btn[0] toggling every 2 cycles for 20 cycles -> mot stays 00, pend stays 00.
REQ-032 btn=11 pressed together -> mot=01 10 cycles, 00 for 3 cycles, mot=10 10 cycles; next double press starts with motor 0 only if motor 1 served last.
REQ-033 Second btn[1] press during RUN1 -> run length still 10, then GAP, then a second 10-cycle RUN1.
REQ-034 rst_n low at run cycle 5 -> mot=00 same cycle, no done, pend=00; after release, idle until new press.
REQ-035 With MOT_EMERGENCY_STOP_EN, stop_n low 6 cycles during RUN0 -> mot=00 within 3 cycles, no done, stays GAP until stop_n high plus 3 cycles, then IDLE with pend=00.

Source files
------------

// File: rtl/motor_cmd_seq.sv
// motor_cmd_seq: two-button motor command sequencer.
// Each button is synchronized and debounced. A debounced press latches one
// pending request per motor. A round-robin FSM (IDLE/RUN0/RUN1/GAP) then
// serves the requests, holding one motor request high for RUN_CYCLES
// cycles and leaving GAP_CYCLES idle cycles after every run.
// Optional feature: define MOT_EMERGENCY_STOP_EN to add the stop_n input.
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   btn    - raw push-buttons, bit i requests motor i
//   stop_n - emergency stop, active-low (only with MOT_EMERGENCY_STOP_EN)
//   mot    - registered motor run requests, at most one bit set
//   busy   - high whenever the FSM is not in IDLE
//   done   - one-cycle pulse on bit i when a run of motor i ends
module motor_cmd_seq #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned RUN_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned CNT_W      = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] btn,
`ifdef MOT_EMERGENCY_STOP_EN
    input  logic       stop_n,
`endif
    output logic [1:0] mot,
    output logic       busy,
    output logic [1:0] done
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN0 = 2'd1,
        RUN1 = 2'd2,
        GAP  = 2'd3
    } state_e;

    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [CNT_W-1:0] deb_cnt_q [2];
    logic [CNT_W-1:0] deb_cnt_d [2];
    logic [1:0]       rise_c;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [1:0]       pend_q, pend_d;
    logic             rr_q, rr_d;
    logic [1:0]       mot_q, mot_d;
    logic [1:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic [1:0]       clr_c;
    logic             pick_c;
    logic             cur_c;

`ifdef MOT_EMERGENCY_STOP_EN
    logic [1:0]       stop_sync_q;
    logic             stop_c;
    assign stop_c = ~stop_sync_q[1];
`endif

    assign mot  = mot_q;
    assign busy = busy_q;
    assign done = done_q;

    // Debounce: level follows the synchronized input after DEB_CYCLES
    // consecutive differing cycles; any agreeing cycle restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            rise_c[i]    = 1'b0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] >= DEB_LAST) begin
                    deb_d[i]  = sync2_q[i];
                    rise_c[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        rr_d      = rr_q;
        mot_d     = 2'b00;
        done_d    = 2'b00;
        clr_c     = 2'b00;
        pick_c    = 1'b0;
        cur_c     = (state_q == RUN1);

        case (state_q)
            IDLE: begin
                if (pend_q != 2'b00) begin
                    // Both pending: rr_q names the motor with priority.
                    pick_c        = (pend_q == 2'b11) ? rr_q : pend_q[1];
                    state_d       = pick_c ? RUN1 : RUN0;
                    mot_d[pick_c] = 1'b1;
                    clr_c[pick_c] = 1'b1;
                    rr_d          = ~pick_c;
                    run_cnt_d     = RUN_LAST;
                end
            end
            RUN0, RUN1: begin
                if (run_cnt_q == '0) begin
                    state_d       = GAP;
                    done_d[cur_c] = 1'b1;
                    run_cnt_d     = GAP_LAST;
                end else begin
                    mot_d[cur_c] = 1'b1;
                    run_cnt_d    = run_cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (run_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    run_cnt_d = run_cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A press arriving in the grant cycle is a new edge and stays queued.
        pend_d = (pend_q & ~clr_c) | rise_c;

`ifdef MOT_EMERGENCY_STOP_EN
        // Stop parks the FSM in GAP; the gap timer restarts once released.
        if (stop_c) begin
            state_d   = GAP;
            mot_d     = 2'b00;
            done_d    = 2'b00;
            pend_d    = 2'b00;
            rr_d      = rr_q;
            run_cnt_d = GAP_LAST;
        end
`endif

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            deb_q        <= 2'b00;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            state_q      <= IDLE;
            run_cnt_q    <= '0;
            pend_q       <= 2'b00;
            rr_q         <= 1'b0;
            mot_q        <= 2'b00;
            done_q       <= 2'b00;
            busy_q       <= 1'b0;
`ifdef MOT_EMERGENCY_STOP_EN
            stop_sync_q  <= 2'b11;
`endif
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            pend_q       <= pend_d;
            rr_q         <= rr_d;
            mot_q        <= mot_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
`ifdef MOT_EMERGENCY_STOP_EN
            stop_sync_q  <= {stop_sync_q[0], stop_n};
`endif
        end
    end

endmodule

// File: tb/tb_motor_cmd_seq.sv
// Scoreboard bench for motor_cmd_seq (DEB=4, RUN=10, GAP=3).
// Stimulus pushes the expected motor of each run; a monitor pops one entry
// per observed run and checks motor, run length, done pulse and gap length.
module tb_motor_cmd_seq;

    localparam int unsigned DEB = 4;
    localparam int unsigned RUN = 10;
    localparam int unsigned GAP = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn   = 2'b00;
    logic [1:0] mot;
    logic [1:0] done;
    logic       busy;
`ifdef MOT_EMERGENCY_STOP_EN
    logic       stop_n = 1'b1;
`endif

    always #5 clk = ~clk;

    motor_cmd_seq #(
        .DEB_CYCLES(DEB),
        .RUN_CYCLES(RUN),
        .GAP_CYCLES(GAP),
        .CNT_W     (28)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
`ifdef MOT_EMERGENCY_STOP_EN
        .stop_n(stop_n),
`endif
        .mot   (mot),
        .busy  (busy),
        .done  (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Run/gap monitor, sampled on the falling edge.
    bit         in_run = 1'b0;
    bit         in_gap = 1'b0;
    int         run_len = 0;
    int         gap_len = 0;
    logic [1:0] cur = 2'b00;
    int         nxt;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_run = 1'b0;
            in_gap = 1'b0;
        end else if (mot != 2'b00) begin
            if (!in_run) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_run", int'(mot), 0);
                end else begin
                    nxt = exp_q.pop_front();
                    chk("run_motor", int'(mot), 1 << nxt);
                end
                in_run  = 1'b1;
                run_len = 1;
                cur     = mot;
            end else begin
                if (mot != cur) chk("mot_switch", int'(mot), int'(cur));
                run_len++;
            end
        end else if (in_run) begin
            chk("run_len", run_len, RUN);
            chk("done_pulse", int'(done), int'(cur));
            in_run  = 1'b0;
            in_gap  = 1'b1;
            gap_len = 1;
        end else if (in_gap) begin
            if (busy) begin
                gap_len++;
            end else begin
                chk("gap_len", gap_len, GAP);
                in_gap = 1'b0;
            end
        end
    end

    task automatic press(input logic [1:0] b, input int hold);
        @(negedge clk);
        btn = b;
        repeat (hold) @(negedge clk);
        btn = 2'b00;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((busy || mot != 2'b00 || in_run || in_gap || exp_q.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk("timeout_idle", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_mot(input logic [1:0] v, input int maxc);
        int n;
        n = 0;
        while (mot !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (mot !== v) chk("timeout_mot", int'(mot), int'(v));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mot", int'(mot), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Double press right after reset: motor 0 first
        exp_q.push_back(0);
        exp_q.push_back(1);
        press(2'b11, 6);
        wait_idle(200);

        // Single press of motor 0
        exp_q.push_back(0);
        press(2'b01, 8);
        wait_idle(100);

        // Bouncing button never debounces
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k % 2 == 0) btn[0] = ~btn[0];
            if (mot != 2'b00 || busy) seen++;
        end
        btn = 2'b00;
        repeat (10) begin
            @(negedge clk);
            if (mot != 2'b00 || busy) seen++;
        end
        chk("glitch_activity", seen, 0);
        chk("glitch_busy", int'(busy), 0);

        // Motor 0 served last: double press grants motor 1 first
        exp_q.push_back(1);
        exp_q.push_back(0);
        press(2'b11, 6);
        wait_idle(200);

        // Motor 1 served last: double press grants motor 0 first
        exp_q.push_back(1);
        press(2'b10, 6);
        wait_idle(100);
        exp_q.push_back(0);
        exp_q.push_back(1);
        press(2'b11, 6);
        wait_idle(200);

        // Re-press of motor 1 during its run is served after the gap
        exp_q.push_back(0);
        press(2'b01, 6);
        wait_mot(2'b01, 50);
        exp_q.push_back(1);
        press(2'b10, 6);
        wait_mot(2'b10, 50);
        exp_q.push_back(1);
        press(2'b10, 6);
        wait_idle(200);

        // Reset in the middle of a run
        exp_q.push_back(0);
        press(2'b01, 6);
        wait_mot(2'b01, 50);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mot", int'(mot), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("postrst_mot", int'(mot), 0);
        chk("postrst_busy", int'(busy), 0);

        // Button held across reset release registers as a press
        @(negedge clk);
        rst_n = 1'b0;
        btn   = 2'b01;
        repeat (2) @(negedge clk);
        exp_q.push_back(0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        btn = 2'b00;
        wait_idle(100);

        chk("sb_empty", exp_q.size(), 0);
        chk("final_mot", int'(mot), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
